// File: rtl/tagged_reg_file.sv
// Architectural register file with per-register rename tags.
// Dispatch reads two operands and renames a destination. ROB commit writes
// data and releases matching tags. The operand lookup sees this cycle's commit
// through a bypass. Flush drops every pending tag. A registered counter tracks
// how many registers are waiting on a writer.
// Optional build macro TRF_DEBUG_PORT_EN adds a combinational read port
// (dbg_addr/dbg_data) that returns the committed register value.

module tagged_reg_file_checker #(
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic [AW:0]      pending_cnt
);

    // Tag 0 means "no pending writer", so dispatch must never hand it out.
    property p_disp_tag_nonzero;
        @(posedge clk) disable iff (rst) disp_valid |-> (disp_tag != '0);
    endproperty
    a_disp_tag_nonzero: assert property (p_disp_tag_nonzero);

    // Register 0 is never renamed, so at most NREG-1 registers can be pending.
    property p_pending_bound;
        @(posedge clk) disable iff (rst) pending_cnt <= (AW+1)'(NREG - 1);
    endproperty
    a_pending_bound: assert property (p_pending_bound);

endmodule

module tagged_reg_file #(
    parameter int  XLEN  = 32,
    parameter int  NREG  = 32,
    parameter int  TAG_W = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [AW-1:0]    disp_rs1,
    input  logic [AW-1:0]    disp_rs2,
    input  logic [AW-1:0]    disp_rd,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             commit_valid,
    input  logic [AW-1:0]    commit_rd,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [XLEN-1:0]  commit_data,
    output logic             op_valid,
    output logic [XLEN-1:0]  op1_val,
    output logic [TAG_W-1:0] op1_tag,
    output logic [XLEN-1:0]  op2_val,
    output logic [TAG_W-1:0] op2_tag,
    output logic [AW:0]      pending_cnt
`ifdef TRF_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]    dbg_addr,
    output logic [XLEN-1:0]  dbg_data
`endif
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [TAG_W-1:0] tags_q [NREG];
    logic [TAG_W-1:0] tags_d [NREG];
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic             op_valid_q, op_valid_d;
    logic [XLEN-1:0]  op1_val_q, op1_val_d;
    logic [TAG_W-1:0] op1_tag_q, op1_tag_d;
    logic [XLEN-1:0]  op2_val_q, op2_val_d;
    logic [TAG_W-1:0] op2_tag_q, op2_tag_d;

    logic [AW-1:0]    rs_s     [2];
    logic [XLEN-1:0]  lk_val_s [2];
    logic [TAG_W-1:0] lk_tag_s [2];

    assign rs_s[0] = disp_rs1;
    assign rs_s[1] = disp_rs2;

    // Operand lookup against the post-commit state: a commit to the source
    // register forwards its data, and clears the tag only if it is the writer
    // the register is currently waiting on.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lk_val_s[k] = '0;
            lk_tag_s[k] = '0;
            if (rs_s[k] == '0) begin
                lk_val_s[k] = '0;
                lk_tag_s[k] = '0;
            end else if (commit_valid && (commit_rd == rs_s[k])) begin
                lk_val_s[k] = commit_data;
                if (tags_q[rs_s[k]] == commit_tag) begin
                    lk_tag_s[k] = '0;
                end else begin
                    lk_tag_s[k] = tags_q[rs_s[k]];
                end
            end else begin
                lk_val_s[k] = regs_q[rs_s[k]];
                lk_tag_s[k] = tags_q[rs_s[k]];
            end
        end
    end

    // Next register/tag state: commit writes data, then rename overrides the
    // commit's tag release; flush wipes every tag but keeps committed data.
    always_comb begin
        regs_d = regs_q;
        tags_d = tags_q;
        for (int r = 1; r < NREG; r++) begin
            if (commit_valid && (commit_rd == AW'(r))) begin
                regs_d[r] = commit_data;
            end else begin
                regs_d[r] = regs_q[r];
            end

            if (flush) begin
                tags_d[r] = '0;
            end else if (disp_valid && (disp_rd == AW'(r))) begin
                tags_d[r] = disp_tag;
            end else if (commit_valid && (commit_rd == AW'(r)) &&
                         (tags_q[r] == commit_tag)) begin
                tags_d[r] = '0;
            end else begin
                tags_d[r] = tags_q[r];
            end
        end
        regs_d[0] = '0;
        tags_d[0] = '0;
    end

    // Pending count follows the next tag state, which covers set, clear,
    // re-rename (net zero) and flush in one place.
    always_comb begin
        cnt_d = '0;
        for (int r = 1; r < NREG; r++) begin
            if (tags_d[r] != '0) begin
                cnt_d = cnt_d + (AW+1)'(1);
            end else begin
                cnt_d = cnt_d;
            end
        end
    end

    // Operand output next-state: one-cycle valid pulse per dispatch,
    // suppressed by flush; operand fields hold when no lookup is issued.
    always_comb begin
        op_valid_d = 1'b0;
        op1_val_d  = op1_val_q;
        op1_tag_d  = op1_tag_q;
        op2_val_d  = op2_val_q;
        op2_tag_d  = op2_tag_q;
        if (flush) begin
            op_valid_d = 1'b0;
        end else if (disp_valid) begin
            op_valid_d = 1'b1;
            op1_val_d  = lk_val_s[0];
            op1_tag_d  = lk_tag_s[0];
            op2_val_d  = lk_val_s[1];
            op2_tag_d  = lk_tag_s[1];
        end else begin
            op_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                tags_q[r] <= '0;
            end
            cnt_q      <= '0;
            op_valid_q <= 1'b0;
            op1_val_q  <= '0;
            op1_tag_q  <= '0;
            op2_val_q  <= '0;
            op2_tag_q  <= '0;
        end else begin
            regs_q     <= regs_d;
            tags_q     <= tags_d;
            cnt_q      <= cnt_d;
            op_valid_q <= op_valid_d;
            op1_val_q  <= op1_val_d;
            op1_tag_q  <= op1_tag_d;
            op2_val_q  <= op2_val_d;
            op2_tag_q  <= op2_tag_d;
        end
    end

    assign op_valid    = op_valid_q;
    assign op1_val     = op1_val_q;
    assign op1_tag     = op1_tag_q;
    assign op2_val     = op2_val_q;
    assign op2_tag     = op2_tag_q;
    assign pending_cnt = cnt_q;

`ifdef TRF_DEBUG_PORT_EN
    // Debug read of the committed value; register 0 is stored as zero.
    always_comb begin
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end else begin
            dbg_data = regs_q[dbg_addr];
        end
    end
`endif

    tagged_reg_file_checker #(
        .NREG  (NREG),
        .TAG_W (TAG_W),
        .AW    (AW)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .disp_valid  (disp_valid),
        .disp_tag    (disp_tag),
        .pending_cnt (cnt_q)
    );

endmodule

// File: tb/tb_tagged_reg_file.sv
// Self-checking bench for tagged_reg_file: directed scenarios followed by
// randomized traffic checked against an array-based reference model.

module tb_tagged_reg_file;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             disp_valid;
    logic [AW-1:0]    disp_rs1, disp_rs2, disp_rd;
    logic [TAG_W-1:0] disp_tag;
    logic             commit_valid;
    logic [AW-1:0]    commit_rd;
    logic [TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_data;
    logic             op_valid;
    logic [XLEN-1:0]  op1_val, op2_val;
    logic [TAG_W-1:0] op1_tag, op2_tag;
    logic [AW:0]      pending_cnt;
`ifdef TRF_DEBUG_PORT_EN
    logic [AW-1:0]    dbg_addr;
    logic [XLEN-1:0]  dbg_data;
`endif

    tagged_reg_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_rs1     (disp_rs1),
        .disp_rs2     (disp_rs2),
        .disp_rd      (disp_rd),
        .disp_tag     (disp_tag),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .op_valid     (op_valid),
        .op1_val      (op1_val),
        .op1_tag      (op1_tag),
        .op2_val      (op2_val),
        .op2_tag      (op2_tag),
        .pending_cnt  (pending_cnt)
`ifdef TRF_DEBUG_PORT_EN
        ,
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed values and pending tag per register.
    logic [XLEN-1:0] m_regs [NREG];
    int              m_tags [NREG];
    // Expected operand outputs (held between lookups).
    int              e_valid, e_t1, e_t2;
    logic [XLEN-1:0] e_v1, e_v2;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic int model_pending();
        int c = 0;
        for (int r = 0; r < NREG; r++) if (m_tags[r] != 0) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_tags[r] = 0;
        end
        e_valid = 0; e_t1 = 0; e_t2 = 0; e_v1 = '0; e_v2 = '0;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; disp_valid = 1'b0; disp_rs1 = '0; disp_rs2 = '0;
        disp_rd = '0; disp_tag = 4'd1; commit_valid = 1'b0; commit_rd = '0;
        commit_tag = 4'd1; commit_data = '0;
    endtask

    // Predict one clock from the current inputs, clock it, then compare.
    task automatic step();
        logic [XLEN-1:0] pr [NREG];
        int              pt [NREG];
        pr = m_regs;
        pt = m_tags;
        // Post-commit view of the file.
        if (commit_valid && commit_rd != 0) begin
            pr[commit_rd] = commit_data;
            if (pt[commit_rd] == int'(commit_tag)) pt[commit_rd] = 0;
        end
        if (flush) begin
            e_valid = 0;
        end else if (disp_valid) begin
            e_valid = 1;
            e_v1 = (disp_rs1 == 0) ? '0 : pr[disp_rs1];
            e_t1 = (disp_rs1 == 0) ? 0 : pt[disp_rs1];
            e_v2 = (disp_rs2 == 0) ? '0 : pr[disp_rs2];
            e_t2 = (disp_rs2 == 0) ? 0 : pt[disp_rs2];
        end else begin
            e_valid = 0;
        end
        // Then the rename (or flush) on top of the committed state.
        m_regs = pr;
        m_tags = pt;
        if (flush) begin
            for (int r = 0; r < NREG; r++) m_tags[r] = 0;
        end else if (disp_valid && disp_rd != 0) begin
            m_tags[disp_rd] = int'(disp_tag);
        end
        @(posedge clk);
        #1;
        check_eq("op_valid", 64'(op_valid), 64'(e_valid));
        check_eq("op1_tag", 64'(op1_tag), 64'(e_t1));
        check_eq("op2_tag", 64'(op2_tag), 64'(e_t2));
        if (e_t1 == 0) check_eq("op1_val", 64'(op1_val), 64'(e_v1));
        if (e_t2 == 0) check_eq("op2_val", 64'(op2_val), 64'(e_v2));
        check_eq("pending_cnt", 64'(pending_cnt), 64'(model_pending()));
        idle_inputs();
    endtask

    task automatic dispatch(input int rs1, input int rs2, input int rd, input int tag);
        disp_valid = 1'b1;
        disp_rs1 = AW'(rs1); disp_rs2 = AW'(rs2); disp_rd = AW'(rd);
        disp_tag = TAG_W'(tag);
    endtask

    task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] data);
        commit_valid = 1'b1;
        commit_rd = AW'(rd); commit_tag = TAG_W'(tag); commit_data = data;
    endtask

    initial begin
        int rd_r;
        rst = 1'b1;
        idle_inputs();
`ifdef TRF_DEBUG_PORT_EN
        dbg_addr = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_valid", 64'(op_valid), 64'd0);
        check_eq("rst_pending", 64'(pending_cnt), 64'd0);

        // Some activity, then a reset in the middle of the run.
        dispatch(5, 6, 5, 3); step();
        commit(6, 9, 32'h1234_5678); dispatch(6, 5, 7, 4); step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(op_valid), 64'd0);
        check_eq("midrst_op1_tag", 64'(op1_tag), 64'd0);
        check_eq("midrst_op1_val", 64'(op1_val), 64'd0);
        check_eq("midrst_pending", 64'(pending_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: lookup after reset returns zero values, no tags.
        dispatch(5, 6, 0, 1); step();
        check_eq("s1_valid", 64'(op_valid), 64'd1);
        check_eq("s1_op2_val", 64'(op2_val), 64'd0);
        step();
        check_eq("s1_pulse", 64'(op_valid), 64'd0);

        // 2: rename rd=3 then look it up.
        dispatch(0, 0, 3, 7); step();
        dispatch(3, 0, 0, 1); step();
        check_eq("s2_op1_tag", 64'(op1_tag), 64'd7);
        check_eq("s2_pending", 64'(pending_cnt), 64'd1);

        // 3: commit bypass into a same-cycle lookup.
        dispatch(3, 0, 0, 2); commit(3, 7, 32'hDEAD_BEEF); step();
        check_eq("s3_op1_tag", 64'(op1_tag), 64'd0);
        check_eq("s3_op1_val", 64'(op1_val), 64'hDEAD_BEEF);
        check_eq("s3_pending", 64'(pending_cnt), 64'd0);

        // 4: stale commit does not release a younger writer.
        dispatch(0, 0, 4, 2); step();
        dispatch(0, 0, 4, 5); step();
        commit(4, 2, 32'h11); step();
        check_eq("s4_pending", 64'(pending_cnt), 64'd1);
        dispatch(0, 4, 0, 1); step();
        check_eq("s4_op2_tag", 64'(op2_tag), 64'd5);

        // 5: flush with a same-cycle commit; rename in that cycle is dropped.
        dispatch(0, 0, 1, 1); step();
        dispatch(0, 0, 2, 2); step();
        dispatch(0, 0, 9, 3); step();
        flush = 1'b1; dispatch(1, 2, 10, 6); commit(9, 3, 32'h42); step();
        check_eq("s5_valid", 64'(op_valid), 64'd0);
        check_eq("s5_pending", 64'(pending_cnt), 64'd0);
        dispatch(9, 0, 0, 1); step();
        check_eq("s5_op1_val", 64'(op1_val), 64'h42);
        check_eq("s5_op1_tag", 64'(op1_tag), 64'd0);

        // 6: register 0 ignores rename and commit.
        dispatch(0, 0, 0, 3); commit(0, 3, 32'hFF); step();
        dispatch(0, 0, 0, 1); step();
        check_eq("s6_op1_val", 64'(op1_val), 64'd0);
        check_eq("s6_op1_tag", 64'(op1_tag), 64'd0);
        check_eq("s6_pending", 64'(pending_cnt), 64'd0);
`ifdef TRF_DEBUG_PORT_EN
        dbg_addr = AW'(9);
        #1;
        check_eq("s6_dbg", 64'(dbg_data), 64'h42);
        dbg_addr = AW'(4);
        #1;
        check_eq("s4_dbg", 64'(dbg_data), 64'h11);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rd_r = $urandom_range(0, NREG - 1);
            if ($urandom_range(0, 1) == 1) begin
                commit_valid = 1'b1;
                commit_rd    = AW'(rd_r);
                if (m_tags[rd_r] != 0 && $urandom_range(0, 2) != 0)
                    commit_tag = TAG_W'(m_tags[rd_r]);
                else
                    commit_tag = TAG_W'($urandom_range(1, 15));
                commit_data = $urandom;
            end
            if ($urandom_range(0, 3) != 0) begin
                disp_valid = 1'b1;
                disp_rs1 = ($urandom_range(0, 2) == 0) ? AW'(rd_r) : AW'($urandom_range(0, NREG - 1));
                disp_rs2 = AW'($urandom_range(0, NREG - 1));
                disp_rd  = AW'($urandom_range(0, NREG - 1));
                disp_tag = TAG_W'($urandom_range(1, 15));
            end
            flush = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
